memory_bus_arbiter: RTL and testbench
=====================================

// Module: memory_bus_arbiter
// PURPOSE
//  Shares one main-memory block port between the instruction-cache refill path and the
//  data-cache refill/writeback path. Sits below instruction_fetch_unit and memory_access_unit:
//  grants one requester at a time, sequences the memory access, and returns the block plus
//  busywait to that requester. The pipeline stall logic sees each requester's busywait unchanged.
// PARAMETERS
//  ADDR_WIDTH   28   block address width (byte address >> 4)
//  BLOCK_WIDTH  128  data block width in bits
// PORTS
//  clk            in   1            system clock; all state updates on rising edge
//  reset          in   1            asynchronous, active-low reset
//  i_read         in   1            I-cache block read request; held until i_busywait=0
//  i_address      in   ADDR_WIDTH   I-cache block address
//  i_readdata     out  BLOCK_WIDTH  block returned to I-cache; valid while i_busywait=0 in I_DONE
//  i_busywait     out  1            1 = I-cache must hold its request
//  d_read         in   1            D-cache block read request
//  d_write        in   1            D-cache block writeback request
//  d_address      in   ADDR_WIDTH   D-cache block address
//  d_writedata    in   BLOCK_WIDTH  D-cache writeback block
//  d_readdata     out  BLOCK_WIDTH  block returned to D-cache
//  d_busywait     out  1            1 = D-cache must hold its request
//  mem_read       out  1            read strobe to main memory
//  mem_write      out  1            write strobe to main memory
//  mem_address    out  ADDR_WIDTH   main-memory block address
//  mem_writedata  out  BLOCK_WIDTH  main-memory write block
//  mem_readdata   in   BLOCK_WIDTH  main-memory read block
//  mem_busywait   in   1            1 = main memory access in progress
// BEHAVIOUR
//  - FSM: IDLE, I_ACCESS, D_ACCESS, I_DONE, D_DONE. Regs: state, started, rdata_q, last_grant.
//  - Reset (async, reset=0): state=IDLE, started=0, rdata_q=0, last_grant=I. Outputs while in
//    reset: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, i/d_readdata=0,
//    i_busywait=i_read, d_busywait=d_read|d_write. Reset mid-access abandons it; no retry.
//  - IDLE: only I -> I_ACCESS; only D -> D_ACCESS; both -> winner per CONFIGURATION. None: stay.
//  - X_ACCESS: mem_* driven combinationally from granted requester (address, writedata,
//    read/write strobes); other requester's busywait=1. First cycle sets started=1.
//    Completion = rising edge with started=1 and mem_busywait=0: rdata_q<=mem_readdata,
//    started<=0, state -> X_DONE, last_grant<=X.
//  - X_DONE (exactly 1 cycle): mem_read=mem_write=0; X_busywait=0; X_readdata=rdata_q;
//    other requester busywait=1 if requesting. Next state always IDLE (1-cycle bus turnaround).
//  - busywait = 1 whenever a requester's request is high and state is not its X_DONE.
//  - d_read and d_write both high: treated as write; read ignored.
//  - Request dropped mid-access (protocol violation): access runs to completion, DONE still
//    visited, data discarded.
//  - Latency: request high in IDLE at edge n -> ACCESS cycle n+1 -> memory latency L cycles ->
//    DONE one cycle -> IDLE. Uncontended read = L+2 cycles of busywait beyond issue.
//  - readdata outputs are 0 outside their DONE state.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE granted to the requester not equal
//    to last_grant (reset last_grant=I, so D wins first contention), alternating thereafter.
//  Undefined: fixed priority, D always wins contention (data stalls the whole pipeline);
//    last_grant still maintained but unused.
// TESTING
//  1 Reset: hold reset=0 with i_read=1 -> mem_read=0, i_busywait=1, state IDLE; release, grant I.
//  2 I read alone, addr 0x0000010, memory L=5 returns 0xDEAD...BEEF -> mem_read high 6 cycles,
//    i_busywait falls exactly one cycle with i_readdata=0xDEAD...BEEF, then mem_read=0.
//  3 d_write addr 0x0000020, data 0x1234..: mem_write=1, mem_address=0x0000020, mem_read=0;
//    d_busywait=0 in D_DONE only; d_readdata stays 0.
//  4 i_read and d_read rise same cycle: without macro D serviced first, then I after a
//    1-cycle IDLE gap; with ARB_ROUND_ROBIN_EN, three contentions grant D, I, D.
//  5 Reset asserted mid D_ACCESS -> mem_read/mem_write drop same cycle, no D_DONE; after
//    release a held d_read is re-granted from IDLE.
//  6 d_read=d_write=1 -> mem_write=1, mem_read=0; single completion.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_bus_arbiter: shares one main-memory block port between the I-cache  |
// | refill path and the D-cache refill/writeback path.                         |
// | Option macro: ARB_ROUND_ROBIN_EN (alternating grant under contention).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_read,
  input  logic [ADDR_WIDTH-1:0]  i_address,
  output logic [BLOCK_WIDTH-1:0] i_readdata,
  output logic                   i_busywait,
  input  logic                   d_read,
  input  logic                   d_write,
  input  logic [ADDR_WIDTH-1:0]  d_address,
  input  logic [BLOCK_WIDTH-1:0] d_writedata,
  output logic [BLOCK_WIDTH-1:0] d_readdata,
  output logic                   d_busywait,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [BLOCK_WIDTH-1:0] mem_writedata,
  input  logic [BLOCK_WIDTH-1:0] mem_readdata,
  input  logic                   mem_busywait
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_I_ACCESS = 3'd1,
    S_D_ACCESS = 3'd2,
    S_I_DONE   = 3'd3,
    S_D_DONE   = 3'd4
  } state_t;

  localparam logic c_grant_i = 1'b0;
  localparam logic c_grant_d = 1'b1;

  state_t                 state_q, state_d;
  logic                   started_q, started_d;
  logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
  logic                   last_grant_q, last_grant_d;

  logic w_i_req;
  logic w_d_req;
  logic w_d_wins;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Tie-break used only when both requesters are waiting in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  assign w_d_wins = (last_grant_q == c_grant_i);
`else
  assign w_d_wins = 1'b1;
`endif

  assign i_busywait = w_i_req & (state_q != S_I_DONE);
  assign d_busywait = w_d_req & (state_q != S_D_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      started_q    <= 1'b0;
      rdata_q      <= '0;
      last_grant_q <= c_grant_i;
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      rdata_q      <= rdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    started_d     = started_q;
    rdata_d       = rdata_q;
    last_grant_d  = last_grant_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    i_readdata    = '0;
    d_readdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (w_i_req && w_d_req) begin
          state_d = w_d_wins ? S_D_ACCESS : S_I_ACCESS;
        end else if (w_i_req) begin
          state_d = S_I_ACCESS;
        end else if (w_d_req) begin
          state_d = S_D_ACCESS;
        end
      end

      S_I_ACCESS: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        if (!started_q) begin
          started_d = 1'b1;
        end else if (!mem_busywait) begin
          rdata_d      = mem_readdata;
          started_d    = 1'b0;
          state_d      = S_I_DONE;
          last_grant_d = c_grant_i;
        end
      end

      S_D_ACCESS: begin
        // Write dominates; a read strobe stays up if the request is dropped mid-access.
        mem_write     = d_write;
        mem_read      = ~d_write;
        mem_address   = d_address;
        mem_writedata = d_writedata;
        if (!started_q) begin
          started_d = 1'b1;
        end else if (!mem_busywait) begin
          rdata_d      = mem_readdata;
          started_d    = 1'b0;
          state_d      = S_D_DONE;
          last_grant_d = c_grant_d;
        end
      end

      S_I_DONE: begin
        i_readdata = rdata_q;
        state_d    = S_IDLE;
      end

      S_D_DONE: begin
        d_readdata = rdata_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memory_bus_arbiter: directed scenarios plus randomized requesters        |
// | against a transaction-level reference of the shared memory port.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_memory_bus_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [BW-1:0] C_BLK_I = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_read = 1'b0, i_busywait;
  logic [AW-1:0] i_address = '0;
  logic [BW-1:0] i_readdata;
  logic          d_read = 1'b0, d_write = 1'b0, d_busywait;
  logic [AW-1:0] d_address = '0;
  logic [BW-1:0] d_writedata = '0, d_readdata;
  logic          mem_read, mem_write, mem_busywait;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_writedata, mem_readdata;

  int n_cmp = 0;
  int n_err = 0;
  bit m_last = 1'b0;   // reference: last requester to complete (0 = I, 1 = D)

  logic [BW-1:0] mem_arr [0:127];
  logic [BW-1:0] ref_mem [0:127];
  int mem_lat = 3;
  int mem_cnt = 0;

  memory_bus_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] idx(input logic [AW-1:0] a);
    return {a[27], a[5:0]};
  endfunction

  function automatic logic [BW-1:0] dflt(input logic [AW-1:0] a);
    return {a, 4'h5, a ^ 28'h5A5A5A5, 4'hA, ~a, 4'h3, a + 28'd17, 4'hC};
  endfunction

  function automatic bit exp_d_wins(input bit ir, input bit dr, input bit last);
    if (ir && dr) return RR ? !last : 1'b1;
    return dr;
  endfunction

  // Main-memory model: busy for mem_lat cycles of a held strobe, then data/write.
  assign mem_busywait = (mem_read | mem_write) && (mem_cnt < mem_lat);
  assign mem_readdata = (mem_read && mem_cnt >= mem_lat) ? mem_arr[idx(mem_address)] : '0;

  always @(posedge clk) begin
    if (mem_read | mem_write) begin
      if (mem_write && mem_cnt >= mem_lat) mem_arr[idx(mem_address)] <= mem_writedata;
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_read = 1'b1; i_address = 28'h10; mem_lat = 3;
    repeat (3) cyc();
    n_cmp++;
    if ({mem_read, mem_write, mem_address, i_readdata, i_busywait, d_busywait} !==
        {1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h ibw=%b dbw=%b, need rd=0 wr=0 addr=0 ibw=1 dbw=0",
               mem_read, mem_write, mem_address, i_busywait, d_busywait);
    end
    reset = 1'b1;
    cyc();
    n_cmp++;
    if ({mem_read, mem_address} !== {1'b1, 28'h10}) begin
      n_err++; $display("FAIL reset_grant_i: rd=%b addr=%h, need rd=1 addr=0000010", mem_read, mem_address);
    end
    for (int k = 0; k < 40 && i_busywait; k++) cyc();
    n_cmp++;
    if (i_busywait !== 1'b0 || i_readdata !== ref_mem[idx(28'h10)]) begin
      n_err++; $display("FAIL reset_first_read: bw=%b data=%h need %h", i_busywait, i_readdata, ref_mem[idx(28'h10)]);
    end
    i_read = 1'b0; m_last = 1'b0;
    cyc();
  endtask

  task automatic test_i_read();
    int rd_cyc = 0, low = 0, nz = 0;
    logic [BW-1:0] got = '0;
    mem_lat = 5; i_address = 28'h10; i_read = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (mem_read) rd_cyc++;
      if (i_busywait && i_readdata !== '0) nz++;
      if (i_read && !i_busywait) begin
        low++; got = i_readdata; i_read = 1'b0; m_last = 1'b0;
      end
    end
    n_cmp++;
    if (rd_cyc !== 6) begin n_err++; $display("FAIL i_read_strobe_cycles: got %0d need 6", rd_cyc); end
    n_cmp++;
    if (low !== 1 || got !== C_BLK_I) begin
      n_err++; $display("FAIL i_read_data: done=%0d data=%h need done=1 data=%h", low, got, C_BLK_I);
    end
    n_cmp++;
    if (nz !== 0) begin n_err++; $display("FAIL i_readdata_idle: %0d nonzero samples, need 0", nz); end
  endtask

  task automatic test_d_write();
    logic [BW-1:0] wd = 128'h1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0;
    int bad = 0, acc = 0, low = 0, nz = 0;
    mem_lat = 2; d_address = 28'h20; d_writedata = wd; d_write = 1'b1;
    for (int k = 0; k < 30 && d_write; k++) begin
      cyc();
      if (mem_read | mem_write) begin
        acc++;
        if ({mem_read, mem_write, mem_address, mem_writedata} !== {1'b0, 1'b1, 28'h20, wd}) bad++;
      end
      if (d_readdata !== '0) nz++;
      if (!d_busywait) begin
        low++; d_write = 1'b0; m_last = 1'b1; ref_mem[idx(28'h20)] = wd;
      end
    end
    n_cmp++;
    if (bad !== 0 || acc !== 3) begin
      n_err++; $display("FAIL d_write_bus: bad=%0d access_cycles=%0d, need bad=0 cycles=3", bad, acc);
    end
    n_cmp++;
    if (low !== 1 || nz !== 0) begin
      n_err++; $display("FAIL d_write_done: done=%0d nonzero_rdata=%0d, need 1 and 0", low, nz);
    end
    d_read = 1'b1;
    cyc();
    for (int k = 0; k < 30 && d_busywait; k++) cyc();
    n_cmp++;
    if (d_busywait !== 1'b0 || d_readdata !== wd) begin
      n_err++; $display("FAIL d_write_readback: bw=%b data=%h need %h", d_busywait, d_readdata, wd);
    end
    d_read = 1'b0; m_last = 1'b1;
    cyc();
  endtask

  task automatic test_contention();
    bit [1:0] order = '0;
    int ng = 0, gap = 0;
    bit p_s = 1'b0, first_done = 1'b0, s, w;
    reset = 1'b0; cyc(); reset = 1'b1; m_last = 1'b0;
    w = exp_d_wins(1'b1, 1'b1, m_last);
    mem_lat = 3; i_address = 28'h11; d_address = 28'h8000003;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 80 && (i_read || d_read); k++) begin
      cyc();
      s = mem_read | mem_write;
      if (s && !p_s && ng < 2) begin order[ng] = mem_address[27]; ng++; end
      if (!s && ng == 1 && first_done) gap++;
      p_s = s;
      if (i_read && !i_busywait) begin
        n_cmp++;
        if (i_readdata !== ref_mem[idx(i_address)]) begin
          n_err++; $display("FAIL contention_i_data: got %h need %h", i_readdata, ref_mem[idx(i_address)]);
        end
        i_read = 1'b0; m_last = 1'b0; first_done = 1'b1;
      end
      if (d_read && !d_busywait) begin
        n_cmp++;
        if (d_readdata !== ref_mem[idx(d_address)]) begin
          n_err++; $display("FAIL contention_d_data: got %h need %h", d_readdata, ref_mem[idx(d_address)]);
        end
        d_read = 1'b0; m_last = 1'b1; first_done = 1'b1;
      end
    end
    n_cmp++;
    if (ng !== 2 || order !== {~w, w} || gap !== 1) begin
      n_err++; $display("FAIL contention_order: grants=%0d order=%b gap=%0d, need 2 %b 1", ng, order, gap, {~w, w});
    end
    i_read = 1'b0; d_read = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    bit [2:0] got = '0;
    bit [2:0] exp_seq = RR ? 3'b101 : 3'b111;
    int ng = 0;
    bit p_s = 1'b0;
    mem_lat = 2; i_address = 28'h12; d_address = 28'h8000001;
    i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    for (int k = 0; k < 200 && (i_read || d_read); k++) begin
      cyc();
      if ((mem_read | mem_write) && !p_s && ng < 3) begin got[ng] = mem_address[27]; ng++; end
      p_s = mem_read | mem_write;
      if (i_read && !i_busywait) begin
        n_cmp++;
        if (i_readdata !== ref_mem[idx(i_address)]) begin
          n_err++; $display("FAIL rr_i_data: got %h need %h", i_readdata, ref_mem[idx(i_address)]);
        end
        m_last = 1'b0;
        if (ng >= 3) i_read = 1'b0; else i_address = i_address + 28'd1;
      end
      if (d_read && !d_busywait) begin
        n_cmp++;
        if (d_readdata !== ref_mem[idx(d_address)]) begin
          n_err++; $display("FAIL rr_d_data: got %h need %h", d_readdata, ref_mem[idx(d_address)]);
        end
        m_last = 1'b1;
        if (ng >= 3) d_read = 1'b0; else d_address = d_address + 28'd1;
      end
    end
    n_cmp++;
    if (ng !== 3 || got !== exp_seq || i_read || d_read) begin
      n_err++; $display("FAIL rr_sequence: grants=%0d seq=%b pending=%b%b, need 3 %b 00",
                        ng, got, i_read, d_read, exp_seq);
    end
    i_read = 1'b0; d_read = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    mem_lat = 6; d_address = 28'h8000005; d_read = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if ({mem_read, mem_write} !== 2'b10) begin
      n_err++; $display("FAIL reset_mid_pre: rd=%b wr=%b need rd=1 wr=0", mem_read, mem_write);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_read, mem_write, d_busywait} !== 3'b001) begin
      n_err++; $display("FAIL reset_mid_drop: rd=%b wr=%b bw=%b need 0 0 1", mem_read, mem_write, d_busywait);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (!d_busywait || mem_read || mem_write) bad++;
    end
    reset = 1'b1; m_last = 1'b0;
    cyc();
    n_cmp++;
    if (bad !== 0 || {mem_read, mem_address} !== {1'b1, 28'h8000005}) begin
      n_err++; $display("FAIL reset_mid_regrant: bad=%0d rd=%b addr=%h need 0 1 8000005", bad, mem_read, mem_address);
    end
    for (int k = 0; k < 30 && d_busywait; k++) cyc();
    n_cmp++;
    if (d_busywait !== 1'b0 || d_readdata !== ref_mem[idx(d_address)]) begin
      n_err++; $display("FAIL reset_mid_data: bw=%b got %h need %h", d_busywait, d_readdata, ref_mem[idx(d_address)]);
    end
    d_read = 1'b0; m_last = 1'b1;
    cyc();
  endtask

  task automatic test_both_rw();
    logic [BW-1:0] wd = {$urandom, $urandom, $urandom, $urandom};
    int bad = 0, acc = 0, low = 0, extra = 0;
    mem_lat = 1; d_address = 28'h30; d_writedata = wd; d_read = 1'b1; d_write = 1'b1;
    for (int k = 0; k < 30 && d_read; k++) begin
      cyc();
      if (mem_read | mem_write) begin
        acc++;
        if ({mem_read, mem_write} !== 2'b01) bad++;
      end
      if (!d_busywait) begin
        low++; d_read = 1'b0; d_write = 1'b0; m_last = 1'b1; ref_mem[idx(28'h30)] = wd;
      end
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (mem_read | mem_write) extra++;
    end
    n_cmp++;
    if (bad !== 0 || acc !== 2 || low !== 1 || extra !== 0) begin
      n_err++; $display("FAIL both_rw: bad=%0d cycles=%0d done=%0d extra=%0d, need 0 2 1 0", bad, acc, low, extra);
    end
    i_address = 28'h30; i_read = 1'b1;
    cyc();
    for (int k = 0; k < 30 && i_busywait; k++) cyc();
    n_cmp++;
    if (i_busywait !== 1'b0 || i_readdata !== wd) begin
      n_err++; $display("FAIL both_rw_readback: bw=%b got %h need %h", i_busywait, i_readdata, wd);
    end
    i_read = 1'b0; m_last = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    bit i_act = 1'b0, d_act = 1'b0, p_i = 1'b0, p_d = 1'b0, p_s = 1'b0, s, ret_i, ret_d;
    int i_age = 0, d_age = 0, dop = 0;
    logic [AW+BW+1:0] exp_bus;
    for (int k = 0; k < 1500; k++) begin
      cyc();
      ret_i = 1'b0; ret_d = 1'b0;
      s = mem_read | mem_write;
      if (s && !p_s) begin
        n_cmp++;
        if (mem_address[27] !== exp_d_wins(p_i, p_d, m_last)) begin
          n_err++; $display("FAIL rand_grant: granted D=%b need D=%b (i=%b d=%b last=%b)",
                            mem_address[27], exp_d_wins(p_i, p_d, m_last), p_i, p_d, m_last);
        end
      end
      if (s) begin
        exp_bus = mem_address[27] ? {dop == 0, dop != 0, d_address, d_writedata & {BW{dop != 0}}}
                                  : {1'b1, 1'b0, i_address, {BW{1'b0}}};
        n_cmp++;
        if ({mem_read, mem_write, mem_address, mem_writedata & {BW{mem_write}}} !== exp_bus) begin
          n_err++; $display("FAIL rand_bus: rd=%b wr=%b addr=%h need %b %b %h",
                            mem_read, mem_write, mem_address, exp_bus[AW+BW+1], exp_bus[AW+BW], exp_bus[AW+BW-1:BW]);
        end
      end
      n_cmp++;
      if ((i_busywait && i_readdata !== '0) || (!i_read && i_busywait)) begin
        n_err++; $display("FAIL rand_i_idle: bw=%b req=%b data=%h need data 0 and no bw without req",
                          i_busywait, i_read, i_readdata);
      end
      if (i_act && !i_busywait) begin
        n_cmp++;
        if (i_readdata !== ref_mem[idx(i_address)]) begin
          n_err++; $display("FAIL rand_i_data: addr=%h got %h need %h", i_address, i_readdata, ref_mem[idx(i_address)]);
        end
        m_last = 1'b0; i_act = 1'b0; i_read = 1'b0; ret_i = 1'b1;
      end else if (i_act && ++i_age > 400) begin
        n_cmp++; n_err++; $display("FAIL rand_i_timeout: busywait stuck 1, need completion");
        i_act = 1'b0; i_read = 1'b0;
      end
      if (d_act && !d_busywait) begin
        n_cmp++;
        if (dop == 0) begin
          if (d_readdata !== ref_mem[idx(d_address)]) begin
            n_err++; $display("FAIL rand_d_read: addr=%h got %h need %h", d_address, d_readdata, ref_mem[idx(d_address)]);
          end
        end else begin
          if (d_readdata !== '0) begin
            n_err++; $display("FAIL rand_d_write_rdata: got %h need 0", d_readdata);
          end
          ref_mem[idx(d_address)] = d_writedata;
        end
        m_last = 1'b1; d_act = 1'b0; d_read = 1'b0; d_write = 1'b0; ret_d = 1'b1;
      end else if (d_act && ++d_age > 400) begin
        n_cmp++; n_err++; $display("FAIL rand_d_timeout: busywait stuck 1, need completion");
        d_act = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end
      if (!s && !i_act && !d_act) mem_lat = $urandom_range(0, 6);
      if (k < 1400 && !i_act && !ret_i && $urandom_range(0, 2) == 0) begin
        i_act = 1'b1; i_age = 0; i_address = {22'h0, 6'($urandom)}; i_read = 1'b1;
      end
      if (k < 1400 && !d_act && !ret_d && $urandom_range(0, 3) == 0) begin
        d_act = 1'b1; d_age = 0; dop = $urandom_range(0, 2);
        d_address = {1'b1, 24'h0, 3'($urandom)};
        d_writedata = {$urandom, $urandom, $urandom, $urandom};
        d_read = (dop != 1); d_write = (dop != 0);
      end
      p_i = i_read; p_d = d_read | d_write; p_s = s;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem_arr[i] = dflt({i[6], 21'h0, i[5:0]});
      ref_mem[i] = dflt({i[6], 21'h0, i[5:0]});
    end
    mem_arr[idx(28'h10)] = C_BLK_I;
    ref_mem[idx(28'h10)] = C_BLK_I;
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_round_robin();
    test_reset_mid();
    test_both_rw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, need $finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
